// File: rtl/histogram_threshold.sv
// Stores a 256-bin intensity histogram, then scans from the brightest bin down
// until the accumulated pixel count reaches the latched bright-pixel target.
module histogram_threshold #(
  parameter int unsigned NUM_BINS = 256,
  parameter int unsigned BIN_W    = 16,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned ACC_W    = 24
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [BIN_W-1:0] i_data,
  input  logic             i_last,
  output logic             o_ready,
  input  logic [ACC_W-1:0] i_bright_target,
  output logic [IDX_W-1:0] o_threshold,
  output logic [ACC_W-1:0] o_bright_count,
  output logic [ACC_W-1:0] o_total,
  output logic             o_found,
  output logic             o_len_err,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SCAN,
    S_DONE
  } state_t;

  // Beat counter is one bit wider than a bin index so it can hold NUM_BINS.
  localparam int unsigned         CNT_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0]    NB_CNT = CNT_W'(NUM_BINS);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BIN_W-1:0]   r_mem [NUM_BINS];
  logic [CNT_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_k;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_total;
  logic [ACC_W-1:0]   r_target;
  logic               r_ovf;
  logic               r_len_err_frame;

  logic               r_ready;
  logic [IDX_W-1:0]   r_threshold;
  logic [ACC_W-1:0]   r_bright;
  logic [ACC_W-1:0]   r_total_out;
  logic               r_found;
  logic               r_len_err;

  logic               w_beat;
  logic               w_in_range;
  logic [CNT_W-1:0]   w_nbins;
  logic               w_len_bad;
  logic [ACC_W-1:0]   w_bin_ext;
  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_hit;
  logic               w_stop;
  logic               w_res_xfer;

  assign w_beat     = i_valid & r_ready;
  assign w_in_range = (r_idx < NB_CNT);
  assign w_nbins    = w_in_range ? (r_idx + CNT_W'(1)) : NB_CNT;
  assign w_len_bad  = r_ovf | ~w_in_range | (w_nbins != NB_CNT);

  assign w_bin_ext  = ACC_W'(r_mem[r_k]);
  assign w_acc_sum  = r_acc + w_bin_ext;
  assign w_hit      = (w_acc_sum >= r_target);
  assign w_stop     = (r_state == S_SCAN) && (w_hit || (r_k == '0));
  assign w_res_xfer = (r_state == S_DONE) && i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD:  if (w_beat && i_last) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_stop)           w_state_nxt = S_DONE;
      S_DONE:  if (i_ready)          w_state_nxt = S_LOAD;
      default:                       w_state_nxt = S_LOAD;
    endcase
  end

  // Bin storage has no reset; bins above the frame's length are never read.
  always_ff @(posedge i_clk) begin
    if (w_beat && w_in_range) begin
      r_mem[r_idx[IDX_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx           <= '0;
      r_k             <= '0;
      r_acc           <= '0;
      r_total         <= '0;
      r_target        <= '0;
      r_ovf           <= 1'b0;
      r_len_err_frame <= 1'b0;
      r_ready         <= 1'b0;
      r_threshold     <= '0;
      r_bright        <= '0;
      r_total_out     <= '0;
      r_found         <= 1'b0;
      r_len_err       <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_LOAD);

      if (w_beat) begin
        if (r_idx == '0) begin
          r_target <= i_bright_target;
        end
        if (w_in_range) begin
          r_total <= r_total + ACC_W'(i_data);
          r_idx   <= r_idx + CNT_W'(1);
        end else begin
          r_ovf   <= 1'b1;
        end
        if (i_last) begin
          r_k             <= IDX_W'(w_nbins - CNT_W'(1));
          r_len_err_frame <= w_len_bad;
        end
      end

      // When the scan reaches bin 0 unmet, the running sum equals the total.
      if (r_state == S_SCAN) begin
        r_acc <= w_acc_sum;
        if (w_stop) begin
          r_threshold <= r_k;
          r_bright    <= w_acc_sum;
          r_found     <= w_hit;
          r_total_out <= r_total;
          r_len_err   <= r_len_err_frame;
        end else begin
          r_k <= r_k - IDX_W'(1);
        end
      end

      if (w_res_xfer) begin
        r_idx   <= '0;
        r_acc   <= '0;
        r_total <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign o_ready        = r_ready;
  assign o_valid        = (r_state == S_DONE);
  assign o_threshold    = r_threshold;
  assign o_bright_count = r_bright;
  assign o_total        = r_total_out;
  assign o_found        = r_found;
  assign o_len_err      = r_len_err;

endmodule

// File: tb/tb_histogram_threshold.sv
// Frame-level bench for histogram_threshold: a vector table of frames with
// expected results queued on send and compared when the result handshake occurs.
module tb_histogram_threshold;

  localparam int P_SPARSE = 0;
  localparam int P_ONES   = 1;
  localparam int P_TWOS   = 2;
  localparam int P_RAMP   = 3;
  localparam int P_MAX    = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_valid;
  logic [15:0] i_data;
  logic        i_last;
  logic        o_ready;
  logic [23:0] i_bright_target;
  logic [7:0]  o_threshold;
  logic [23:0] o_bright_count;
  logic [23:0] o_total;
  logic        o_found;
  logic        o_len_err;
  logic        o_valid;
  logic        i_ready;

  histogram_threshold #(
    .NUM_BINS (256),
    .BIN_W    (16),
    .IDX_W    (8),
    .ACC_W    (24)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .i_last          (i_last),
    .o_ready         (o_ready),
    .i_bright_target (i_bright_target),
    .o_threshold     (o_threshold),
    .o_bright_count  (o_bright_count),
    .o_total         (o_total),
    .o_found         (o_found),
    .o_len_err       (o_len_err),
    .o_valid         (o_valid),
    .i_ready         (i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          pat;
    int          nbeats;
    logic [23:0] tgt;
    bit          chg;
    int          stall;
    logic [7:0]  thr;
    logic [23:0] bright;
    logic [23:0] total;
    bit          found;
    bit          lerr;
  } vec_t;

  typedef struct {
    logic [7:0]  thr;
    logic [23:0] bright;
    logic [23:0] total;
    bit          found;
    bit          lerr;
    int          lat;
  } res_t;

  vec_t vecs[10];
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bin_val(input int pat, input int k);
    if (k >= 256) return 16'd100;
    case (pat)
      P_SPARSE: return (k == 10) ? 16'd1000 : (k == 200) ? 16'd30 : (k == 250) ? 16'd5 : 16'd0;
      P_ONES:   return 16'd1;
      P_TWOS:   return 16'd2;
      P_RAMP:   return 16'(k);
      default:  return 16'hFFFF;
    endcase
  endfunction

  task automatic send_frame(input int pat, input int nbeats, input logic [23:0] tgt, input bit chg);
    int w;
    for (int k = 0; k < nbeats; k++) begin
      if (k % 7 == 3) begin
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 16'hDEAD;
        i_last  = 1'b1;
      end
      @(negedge i_clk);
      i_valid         = 1'b1;
      i_data          = bin_val(pat, k);
      i_last          = (k == nbeats - 1);
      i_bright_target = (chg && k > 0) ? 24'd1 : tgt;
      w = 0;
      while (o_ready !== 1'b1 && w < 2000) begin
        @(negedge i_clk);
        w++;
      end
      if (w >= 2000) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge i_clk);
    end
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    res_t r;
    int   nst;
    nst      = (v.nbeats > 256) ? 256 : v.nbeats;
    r.thr    = v.thr;
    r.bright = v.bright;
    r.total  = v.total;
    r.found  = v.found;
    r.lerr   = v.lerr;
    r.lat    = nst - int'(v.thr) + 1;
    exp_q.push_back(r);
  endtask

  task automatic collect(input int stall);
    res_t        e;
    int          cyc;
    bit          stable;
    logic [7:0]  s_thr;
    logic [23:0] s_br;
    logic [23:0] s_tot;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e   = exp_q.pop_front();
    cyc = 1;
    @(negedge i_clk);
    while (o_valid !== 1'b1 && cyc < 3000) begin
      @(negedge i_clk);
      cyc++;
    end
    chk("valid_seen", 32'(o_valid), 32'd1);
    chk("latency", cyc, e.lat);
    if (stall > 0) begin
      stable = 1'b1;
      s_thr  = o_threshold;
      s_br   = o_bright_count;
      s_tot  = o_total;
      repeat (stall) begin
        @(negedge i_clk);
        if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_threshold !== s_thr ||
            o_bright_count !== s_br || o_total !== s_tot) stable = 1'b0;
      end
      chk("stall_stable", 32'(stable), 32'd1);
    end
    chk("threshold", 32'(o_threshold), 32'(e.thr));
    chk("bright_count", 32'(o_bright_count), 32'(e.bright));
    chk("total", 32'(o_total), 32'(e.total));
    chk("found", 32'(o_found), 32'(e.found));
    chk("len_err", 32'(o_len_err), 32'(e.lerr));
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    @(negedge i_clk);
    chk("valid_drop", 32'(o_valid), 32'd0);
    chk("ready_back", 32'(o_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    //            pat       beats tgt        chg stall thr  bright     total      fnd lerr
    vecs[0] = '{P_SPARSE, 256, 24'd20,     1, 0,  8'd200, 24'd35,       24'd1035,     1, 0};
    vecs[1] = '{P_ONES,   256, 24'd300,    0, 20, 8'd0,   24'd256,      24'd256,      0, 0};
    vecs[2] = '{P_ONES,   256, 24'd256,    0, 0,  8'd0,   24'd256,      24'd256,      1, 0};
    vecs[3] = '{P_TWOS,   100, 24'd10,     0, 0,  8'd95,  24'd10,       24'd200,      1, 1};
    vecs[4] = '{P_ONES,   260, 24'd5,      0, 0,  8'd251, 24'd5,        24'd256,      1, 1};
    vecs[5] = '{P_ONES,   1,   24'd1,      0, 0,  8'd0,   24'd1,        24'd1,        1, 1};
    vecs[6] = '{P_RAMP,   256, 24'd255,    0, 0,  8'd255, 24'd255,      24'd32640,    1, 0};
    vecs[7] = '{P_RAMP,   256, 24'd256,    0, 0,  8'd254, 24'd509,      24'd32640,    1, 0};
    vecs[8] = '{P_MAX,    256, 24'hFFFFFF, 0, 0,  8'd0,   24'd16776960, 24'd16776960, 0, 0};
    vecs[9] = '{P_ONES,   256, 24'd0,      0, 0,  8'd255, 24'd1,        24'd256,      1, 0};

    i_reset_n       = 1'b0;
    i_valid         = 1'b0;
    i_data          = '0;
    i_last          = 1'b0;
    i_bright_target = '0;
    i_ready         = 1'b0;

    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_outs", 32'(o_threshold) | 32'(o_bright_count) | 32'(o_total) |
                    32'(o_found) | 32'(o_len_err), 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    chk("post_rst_valid", 32'(o_valid), 32'd0);

    for (int v = 0; v < 10; v++) begin
      push_exp(vecs[v]);
      send_frame(vecs[v].pat, vecs[v].nbeats, vecs[v].tgt, vecs[v].chg);
      collect(vecs[v].stall);
    end

    // Abort a frame mid-scan: no result may appear and outputs return to 0.
    send_frame(P_ONES, 256, 24'd300, 1'b0);
    repeat (10) @(negedge i_clk);
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    chk("no_valid_after_abort", 32'(seen), 32'd0);
    chk("abort_threshold", 32'(o_threshold), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    push_exp(vecs[9]);
    send_frame(P_ONES, 256, 24'd0, 1'b0);
    collect(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
